// File: rtl/regfile_write_arbiter_if.sv
// Writeback-side bundle of the register-file write arbiter: two requester ports,
// decode read addresses, the single WE3/A3/WD3 write port and the hazard flag (+PC redirect with REGARB_PC_REDIRECT_EN).
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic [ADDR_W-1:0] A1;
   logic [ADDR_W-1:0] A2;
   logic              WE3;
   logic [ADDR_W-1:0] A3;
   logic [DATA_W-1:0] WD3;
   logic              raw_hazard;
`ifdef REGARB_PC_REDIRECT_EN
   logic              pc_redirect;
   logic [DATA_W-1:0] pc_target;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  A1, A2,
      output req0_ready, req1_ready,
      output WE3, A3, WD3, raw_hazard,
      output pc_redirect, pc_target
   );
   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output A1, A2,
      input  req0_ready, req1_ready,
      input  WE3, A3, WD3, raw_hazard,
      input  pc_redirect, pc_target
   );
`else
   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  A1, A2,
      output req0_ready, req1_ready,
      output WE3, A3, WD3, raw_hazard
   );
   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output A1, A2,
      input  req0_ready, req1_ready,
      input  WE3, A3, WD3, raw_hazard
   );
`endif
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin share of the register-file write port between ALU (port 0) and load (port 1) writeback, plus decode RAW hazard flag.
// Latency: 1 cycle from accepted request to WE3/A3/WD3; optional REGARB_PC_REDIRECT_EN turns R15 writes into a pc_redirect pulse.
// Backpressure: output stage never stalls; the losing port sees ready=0 and holds its request (waits at most 1 cycle).
module regfile_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input logic                   clk,
   input logic                   rst,
   regfile_write_arbiter_if.slave bus
);
   logic              rr_ptr;
   logic              gnt0;
   logic              gnt1;
   logic              xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              we3_q;
   logic [ADDR_W-1:0] a3_q;
   logic [DATA_W-1:0] wd3_q;
   logic              hazard;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (bus.req0_valid && bus.req1_valid) begin
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
         end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
         end
      end
   end

   // Grants only ever go to a valid port, so either grant is a transfer.
   assign xfer     = gnt0 | gnt1;
   assign sel_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
   assign sel_data = gnt1 ? bus.req1_data : bus.req0_data;

   always_comb begin
      hazard = 1'b0;
      if (!rst) begin
         hazard = (we3_q && (a3_q == bus.A1 || a3_q == bus.A2)) ||
                  (bus.req0_valid && (bus.req0_addr == bus.A1 || bus.req0_addr == bus.A2)) ||
                  (bus.req1_valid && (bus.req1_addr == bus.A1 || bus.req1_addr == bus.A2));
      end
   end

`ifdef REGARB_PC_REDIRECT_EN
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15);
   logic              pc_redirect_q;
   logic [DATA_W-1:0] pc_target_q;
   logic              is_pc;

   assign is_pc = xfer && (sel_addr == PC_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         we3_q         <= 1'b0;
         a3_q          <= '0;
         wd3_q         <= '0;
         rr_ptr        <= 1'b0;
         pc_redirect_q <= 1'b0;
         pc_target_q   <= '0;
      end else begin
         we3_q         <= xfer && !is_pc;
         pc_redirect_q <= is_pc;
         if (xfer && !is_pc) begin
            a3_q  <= sel_addr;
            wd3_q <= sel_data;
         end
         if (is_pc) begin
            pc_target_q <= sel_data;
         end
         if (xfer) begin
            rr_ptr <= gnt0;
         end
      end
   end

   assign bus.pc_redirect = pc_redirect_q;
   assign bus.pc_target   = pc_target_q;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         we3_q  <= 1'b0;
         a3_q   <= '0;
         wd3_q  <= '0;
         rr_ptr <= 1'b0;
      end else begin
         we3_q <= xfer;
         if (xfer) begin
            a3_q   <= sel_addr;
            wd3_q  <= sel_data;
            // Point at the port that lost (or was idle) this time.
            rr_ptr <= gnt0;
         end
      end
   end
`endif

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.WE3        = we3_q;
   assign bus.A3         = a3_q;
   assign bus.WD3        = wd3_q;
   assign bus.raw_hazard = hazard;
endmodule
